// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-control bundle between an instruction source and alu_sequencer.
interface alu_sequencer_if;
  logic        run;
  logic [31:0] IR;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        PCin;
  logic        IncPC;
  logic        MARin;
  logic        MDRin;
  logic        Read;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        Zin;
  logic        Zlowout;
  logic        Zhighout;
  logic        HIin;
  logic        LOin;
  logic [12:0] alu_op;
  logic        busy;
  logic        done;
  logic        illegal;

  modport master (
    output run, IR,
    input  Rout, Rin, PCin, IncPC, MARin, MDRin, Read, MDRout, IRin, Yin, Zin,
    input  Zlowout, Zhighout, HIin, LOin, alu_op, busy, done, illegal
  );

  modport slave (
    input  run, IR,
    output Rout, Rin, PCin, IncPC, MARin, MDRin, Read, MDRout, IRin, Yin, Zin,
    output Zlowout, Zhighout, HIin, LOin, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer: walks T0..T5 for one instruction and emits datapath strobes.
// Outputs are decoded from the present state and IR only, so reset clears them immediately.
module alu_sequencer (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5} state_e;
  typedef enum logic [1:0] {ClsThree, ClsHl, ClsTwo, ClsIll} cls_e;

  state_e      state_q, state_d;
  cls_e        cls;
  logic [12:0] alu_sel;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        unused_ir;

  assign op        = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

  logic [15:0] rout, rin;
  logic        pc_in, inc_pc, mar_in, mdr_in, read, mdr_out, ir_in, y_in, z_in;
  logic        zlow_out, zhigh_out, hi_in, lo_in, busy, done, illegal, last;
  logic [12:0] alu_op;

  // Opcode decode into instruction class and one-hot ALU select.
  always_comb begin
    cls     = ClsIll;
    alu_sel = '0;
    case (op)
      5'b00011: begin cls = ClsThree; alu_sel = 13'h0004; end // add
      5'b00100: begin cls = ClsThree; alu_sel = 13'h0008; end // sub
      5'b00101: begin cls = ClsThree; alu_sel = 13'h0001; end // and
      5'b00110: begin cls = ClsThree; alu_sel = 13'h0002; end // or
      5'b00111: begin cls = ClsThree; alu_sel = 13'h0200; end // ror
      5'b01000: begin cls = ClsThree; alu_sel = 13'h0400; end // rol
      5'b01001: begin cls = ClsThree; alu_sel = 13'h0040; end // shr
      5'b01010: begin cls = ClsThree; alu_sel = 13'h0080; end // shra
      5'b01011: begin cls = ClsThree; alu_sel = 13'h0100; end // shl
      5'b01111: begin cls = ClsHl;    alu_sel = 13'h0020; end // div
      5'b10000: begin cls = ClsHl;    alu_sel = 13'h0010; end // mul
      5'b10001: begin cls = ClsTwo;   alu_sel = 13'h0800; end // neg
      5'b10010: begin cls = ClsTwo;   alu_sel = 13'h1000; end // not
      default:  begin cls = ClsIll;   alu_sel = '0;       end
    endcase
  end

  // Per-state strobe decode and next-state selection.
  always_comb begin
    state_d   = state_q;
    rout      = '0;
    rin       = '0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    read      = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    alu_op    = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    last      = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StT0;
      end
      StT0: begin
        inc_pc  = 1'b1;
        pc_in   = 1'b1;
        mar_in  = 1'b1;
        mdr_in  = 1'b1;
        read    = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        state_d = StT3;
        case (cls)
          ClsThree: begin rout = 16'h0001 << rb; y_in = 1'b1; end
          ClsHl:    begin rout = 16'h0001 << ra; y_in = 1'b1; end
          ClsTwo:   begin rout = 16'h0001 << rb; alu_op = alu_sel; z_in = 1'b1; end
          default:  begin illegal = 1'b1; state_d = StIdle; end
        endcase
      end
      StT3: begin
        state_d = StT4;
        case (cls)
          ClsThree: begin rout = 16'h0001 << rc; alu_op = alu_sel; z_in = 1'b1; end
          ClsHl:    begin rout = 16'h0001 << rb; alu_op = alu_sel; z_in = 1'b1; end
          ClsTwo:   begin zlow_out = 1'b1; rin = 16'h0001 << ra; done = 1'b1; last = 1'b1; end
          default:  state_d = StIdle;
        endcase
      end
      StT4: begin
        case (cls)
          ClsThree: begin zlow_out = 1'b1; rin = 16'h0001 << ra; done = 1'b1; last = 1'b1; end
          ClsHl:    begin zlow_out = 1'b1; lo_in = 1'b1; state_d = StT5; end
          default:  state_d = StIdle;
        endcase
      end
      StT5: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
        last      = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Final T-state: chain straight into the next fetch when run is still requested.
    if (last) state_d = bus.run ? StT0 : StIdle;
  end

  // State register; asynchronous reset returns to IDLE, which zeroes every decoded output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign bus.Rout     = rout;
  assign bus.Rin      = rin;
  assign bus.PCin     = pc_in;
  assign bus.IncPC    = inc_pc;
  assign bus.MARin    = mar_in;
  assign bus.MDRin    = mdr_in;
  assign bus.Read     = read;
  assign bus.MDRout   = mdr_out;
  assign bus.IRin     = ir_in;
  assign bus.Yin      = y_in;
  assign bus.Zin      = z_in;
  assign bus.Zlowout  = zlow_out;
  assign bus.Zhighout = zhigh_out;
  assign bus.HIin     = hi_in;
  assign bus.LOin     = lo_in;
  assign bus.alu_op   = alu_op;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios then random run/IR/reset traffic, every cycle
// compared against a queue of expected per-cycle output vectors built from the opcode tables.
module tb_alu_sequencer;

  typedef struct packed {
    logic [15:0] rout;
    logic [15:0] rin;
    logic        pcin, incpc, marin, mdrin, read, mdrout, irin, yin, zin;
    logic        zlowout, zhighout, hiin, loin;
    logic [12:0] alu_op;
    logic        busy, done, illegal;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    is_t0;
    bit    is_t1;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  ent_t q[$];

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input outs_t got, input outs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o.rout = bus.Rout;       o.rin = bus.Rin;
    o.pcin = bus.PCin;       o.incpc = bus.IncPC;    o.marin = bus.MARin;
    o.mdrin = bus.MDRin;     o.read = bus.Read;      o.mdrout = bus.MDRout;
    o.irin = bus.IRin;       o.yin = bus.Yin;        o.zin = bus.Zin;
    o.zlowout = bus.Zlowout; o.zhighout = bus.Zhighout;
    o.hiin = bus.HIin;       o.loin = bus.LOin;      o.alu_op = bus.alu_op;
    o.busy = bus.busy;       o.done = bus.done;      o.illegal = bus.illegal;
    return o;
  endfunction

  // Instruction class (0=3-op, 1=HL, 2=2-op, 3=illegal) and ALU select bit per opcode table.
  function automatic void classify(input logic [4:0] op, output int cls, output int bitn);
    cls = 3; bitn = 0;
    case (op)
      5'd3:  begin cls = 0; bitn = 2;  end
      5'd4:  begin cls = 0; bitn = 3;  end
      5'd5:  begin cls = 0; bitn = 0;  end
      5'd6:  begin cls = 0; bitn = 1;  end
      5'd7:  begin cls = 0; bitn = 9;  end
      5'd8:  begin cls = 0; bitn = 10; end
      5'd9:  begin cls = 0; bitn = 6;  end
      5'd10: begin cls = 0; bitn = 7;  end
      5'd11: begin cls = 0; bitn = 8;  end
      5'd15: begin cls = 1; bitn = 5;  end
      5'd16: begin cls = 1; bitn = 4;  end
      5'd17: begin cls = 2; bitn = 11; end
      5'd18: begin cls = 2; bitn = 12; end
      default: cls = 3;
    endcase
  endfunction

  function automatic void push_cycle(input outs_t o, input bit t0, input bit t1);
    ent_t e;
    e.o = o; e.is_t0 = t0; e.is_t1 = t1;
    q.push_back(e);
  endfunction

  function automatic void load_fetch();
    outs_t o;
    o = '0; o.busy = 1; o.incpc = 1; o.pcin = 1; o.marin = 1; o.mdrin = 1; o.read = 1;
    push_cycle(o, 1'b1, 1'b0);
    o = '0; o.busy = 1; o.mdrout = 1; o.irin = 1;
    push_cycle(o, 1'b0, 1'b1);
  endfunction

  // Remaining T-states (T2 onward) of the instruction held in ir.
  function automatic void append_body(input logic [31:0] ir);
    int cls, bitn;
    int ra, rb, rc;
    outs_t o;
    classify(ir[31:27], cls, bitn);
    ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    case (cls)
      0: begin
        o = '0; o.busy = 1; o.rout[rb] = 1; o.yin = 1;                          push_cycle(o, 0, 0);
        o = '0; o.busy = 1; o.rout[rc] = 1; o.alu_op[bitn] = 1; o.zin = 1;      push_cycle(o, 0, 0);
        o = '0; o.busy = 1; o.zlowout = 1; o.rin[ra] = 1; o.done = 1;           push_cycle(o, 0, 0);
      end
      1: begin
        o = '0; o.busy = 1; o.rout[ra] = 1; o.yin = 1;                          push_cycle(o, 0, 0);
        o = '0; o.busy = 1; o.rout[rb] = 1; o.alu_op[bitn] = 1; o.zin = 1;      push_cycle(o, 0, 0);
        o = '0; o.busy = 1; o.zlowout = 1; o.loin = 1;                          push_cycle(o, 0, 0);
        o = '0; o.busy = 1; o.zhighout = 1; o.hiin = 1; o.done = 1;             push_cycle(o, 0, 0);
      end
      2: begin
        o = '0; o.busy = 1; o.rout[rb] = 1; o.alu_op[bitn] = 1; o.zin = 1;      push_cycle(o, 0, 0);
        o = '0; o.busy = 1; o.zlowout = 1; o.rin[ra] = 1; o.done = 1;           push_cycle(o, 0, 0);
      end
      default: begin
        o = '0; o.busy = 1; o.illegal = 1;                                      push_cycle(o, 0, 0);
      end
    endcase
  endfunction

  // One clock: check the present cycle, drive inputs, then advance the model at the edge.
  // IR may only change while idle or in T0, since it must be stable from T2 on.
  task automatic step(input bit run_v, input logic [31:0] ir_v, input bit rst_v);
    outs_t exp;
    ent_t  e;
    @(negedge clk);
    exp = (q.size() == 0) ? outs_t'('0) : q[0].o;
    check_out("cycle", dut_outs(), exp);
    if (q.size() == 0 || q[0].is_t0) bus.IR = ir_v;
    bus.run = run_v;
    if (rst_v && !reset) begin
      reset = 1'b1;
      #1;
      check_out("rst_async", dut_outs(), outs_t'('0));
    end
    reset = rst_v;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (bus.run) load_fetch();
    end else begin
      e = q.pop_front();
      if (e.is_t1) append_body(bus.IR);
      if (e.o.done && bus.run) load_fetch();
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0]  legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                    5'd15, 5'd16, 5'd17, 5'd18};
    logic [31:0] r;
    logic [4:0]  op;
    r  = $urandom();
    op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 12)] : r[31:27];
    return {op, r[26:0]};
  endfunction

  localparam logic [31:0] IrMul = 32'h8130_0000;
  localparam logic [31:0] IrAdd = 32'h1A92_0000;
  localparam logic [31:0] IrNeg = 32'h8898_0000;
  localparam logic [31:0] IrIll = 32'hF800_0000;

  initial begin
    bus.run = 1'b0;
    bus.IR  = '0;
    reset   = 1'b1;
    repeat (3) step(1'b1, 32'h0, 1'b1);

    // Single instructions with run held for one cycle.
    step(1'b1, IrMul, 1'b0); repeat (8) step(1'b0, IrMul, 1'b0);
    step(1'b1, IrAdd, 1'b0); repeat (7) step(1'b0, IrAdd, 1'b0);
    step(1'b1, IrNeg, 1'b0); repeat (6) step(1'b0, IrNeg, 1'b0);
    step(1'b1, IrIll, 1'b0); repeat (5) step(1'b0, IrIll, 1'b0);

    // Back-to-back adds with run held high.
    repeat (7) step(1'b1, IrAdd, 1'b0);
    repeat (6) step(1'b0, IrAdd, 1'b0);

    // Reset landing in T3 of a mul, with run requested while reset is held.
    step(1'b1, IrMul, 1'b0);
    repeat (3) step(1'b0, IrMul, 1'b0);
    step(1'b0, IrMul, 1'b1);
    step(1'b1, IrMul, 1'b1);
    repeat (3) step(1'b0, IrMul, 1'b0);
    step(1'b1, IrNeg, 1'b0);
    repeat (6) step(1'b0, IrNeg, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, rand_ir(), $urandom_range(0, 149) == 0);
    end
    repeat (8) step(1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces IDLE and all outputs low.
REQ-003 run  in  1  level request to fetch and execute one instruction; sampled in IDLE and in each final T-state.
REQ-004 IR  in  32  datapath IR contents; fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]; valid from T2 onward.
REQ-005 Rout  out  16  one-hot register-to-bus enable; bit i drives Ri onto the bus.
REQ-006 Rin  out  16  one-hot register load enable; bit i loads Ri.
REQ-007 PCin, IncPC, MARin, MDRin, Read, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
REQ-008 alu_op  out  13  one-hot ALU select, bit0..12 = AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse in the last T-state of a legal instruction.
REQ-011 illegal  out  1  one-cycle pulse when op is not in the opcode table.

Function
REQ-012 States: IDLE, T0, T1, T2, T3, T4, T5; binary encoded; all outputs are decoded from present state and IR only (no combinational path from run).
REQ-013 Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, div 01111, mul 10000, neg 10001, not 10010; every other value is illegal.
REQ-014 Classes: 3-op = add/sub/and/or/ror/rol/shr/shra/shl; HL = mul/div; 2-op = neg/not.
REQ-015 IDLE: all outputs 0; run=1 -> T0, else stay.
REQ-016 T0 (fetch): IncPC, PCin, MARin, MDRin, Read = 1; -> T1.
REQ-017 T1: MDRout, IRin = 1; -> T2.
REQ-018 T2: 3-op: Rout[Rb], Yin; HL: Rout[Ra], Yin; 2-op: Rout[Rb], alu_op, Zin; illegal: only illegal=1, -> IDLE; legal -> T3.
REQ-019 T3: 3-op: Rout[Rc], alu_op, Zin; HL: Rout[Rb], alu_op, Zin; 2-op: Zlowout, Rin[Ra], done (final).
REQ-020 T4: 3-op: Zlowout, Rin[Ra], done (final); HL: Zlowout, LOin; -> T5.
REQ-021 T5 (HL only): Zhighout, HIin, done (final).
REQ-022 Final state: run=1 -> T0 (back-to-back, no IDLE cycle); run=0 -> IDLE.
REQ-023 alu_op asserted only in the Zin cycle, exactly one bit set, matching op.
REQ-024 Rout and Rin never both nonzero in the same cycle; each has at most one bit set.
REQ-025 run deasserted mid-sequence is ignored; the instruction completes.
REQ-026 Latency: 3-op 5 cycles, HL 6, 2-op 4, illegal 3 (T0-T2), counted from the first T0 cycle.

Reset
REQ-027 Reset assertion at any time, including mid-sequence, immediately forces IDLE with every output 0; no partial register write completes after the reset edge.
REQ-028 First sampled run after reset deassertion starts at T0; no residual done or illegal pulse is produced.

Verification
REQ-029 IR=0x81300000 (mul R2,R6), run held one cycle -> T2 Rout=0x0004,Yin; T3 Rout=0x0040,alu_op=0x0010,Zin; T4 Zlowout,LOin; T5 Zhighout,HIin,done; then IDLE.
REQ-030 IR=0x1A920000 (add R5,R2,R4) -> T2 Rout=0x0004; T3 Rout=0x0010,alu_op=0x0004; T4 Zlowout,Rin=0x0020,done.
REQ-031 IR=0x88980000 (neg R1,R3) -> T2 Rout=0x0008,alu_op=0x0800,Zin; T3 Zlowout,Rin=0x0002,done; total 4 cycles.
REQ-032 IR=0xF8000000 -> illegal pulses in T2, done never asserts, Rout/Rin stay 0, IDLE next.
REQ-033 run held high across two add instructions -> T4 of the first is followed directly by T0, busy stays high, done pulses twice.
REQ-034 reset asserted during T3 of mul -> all outputs 0 within the same cycle, HIin/LOin never assert, busy=0 until the next run.
